// File: rtl/ternary_match_table.sv
// Ternary match table: lowest-index-wins masked lookup with a two-stage pipeline,
// saturating per-entry packet/byte counters and a one-entry-per-cycle flush sweep.
module ternary_match_table #(
  parameter int KEY_WIDTH      = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 32,
  parameter int PKT_SIZE_WIDTH = 12,
  parameter int PKT_CNT_WIDTH  = 32,
  parameter int BYTE_CNT_WIDTH = 48,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lookup_req,
  input  logic [KEY_WIDTH-1:0]      lookup_key,
  input  logic [PKT_SIZE_WIDTH-1:0] lookup_pkt_size,
  output logic                      lookup_rdy,
  output logic                      lookup_ack,
  output logic                      lookup_hit,
  output logic                      lookup_miss,
  output logic [DATA_WIDTH-1:0]     lookup_data,
  output logic [ADDR_WIDTH-1:0]     lookup_addr,
  input  logic                      wr_req,
  input  logic                      wr_valid,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [KEY_WIDTH-1:0]      wr_key,
  input  logic [KEY_WIDTH-1:0]      wr_mask,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_ack,
  input  logic                      cnt_rd_req,
  input  logic                      cnt_rd_clear,
  input  logic [ADDR_WIDTH-1:0]     cnt_rd_addr,
  output logic                      cnt_rd_ack,
  output logic [PKT_CNT_WIDTH-1:0]  cnt_pkts,
  output logic [BYTE_CNT_WIDTH-1:0] cnt_bytes,
  input  logic                      flush,
  output logic                      busy
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   flush_idx_q;
  logic                    busy_q;

  logic [KEY_WIDTH-1:0]      key_q   [DEPTH];
  logic [KEY_WIDTH-1:0]      mask_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q  [DEPTH];
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [PKT_CNT_WIDTH-1:0]  pkts_q  [DEPTH], pkts_d  [DEPTH], pkts_base_s  [DEPTH];
  logic [BYTE_CNT_WIDTH-1:0] bytes_q [DEPTH], bytes_d [DEPTH], bytes_base_s [DEPTH];

  logic                  idle_s, lk_accept_s, wr_accept_s, rd_accept_s;
  logic [DEPTH-1:0]      match_s, clr_s, inc_s;
  logic                  hit_s;
  logic [ADDR_WIDTH-1:0] hit_addr_s;
  logic [DATA_WIDTH-1:0] hit_data_s;

  logic                      s1_vld_q, s1_hit_q;
  logic [ADDR_WIDTH-1:0]     s1_addr_q;
  logic [DATA_WIDTH-1:0]     s1_data_q;
  logic [PKT_SIZE_WIDTH-1:0] s1_size_q;
  logic                      ack_q, ack_hit_q, ack_miss_q;
  logic [ADDR_WIDTH-1:0]     ack_addr_q;
  logic [DATA_WIDTH-1:0]     ack_data_q;
  logic [PKT_SIZE_WIDTH-1:0] ack_size_q;
  logic                      wr_ack_q, rd_ack_q;
  logic [PKT_CNT_WIDTH-1:0]  rd_pkts_q;
  logic [BYTE_CNT_WIDTH-1:0] rd_bytes_q;

  function automatic logic [PKT_CNT_WIDTH-1:0] sat_inc(input logic [PKT_CNT_WIDTH-1:0] b);
    return (&b) ? b : b + PKT_CNT_WIDTH'(1);
  endfunction

  function automatic logic [BYTE_CNT_WIDTH-1:0] sat_add(input logic [BYTE_CNT_WIDTH-1:0] b,
                                                        input logic [PKT_SIZE_WIDTH-1:0] s);
    logic [BYTE_CNT_WIDTH:0] sum;
    sum = {1'b0, b} + {{(BYTE_CNT_WIDTH + 1 - PKT_SIZE_WIDTH){1'b0}}, s};
    return sum[BYTE_CNT_WIDTH] ? {BYTE_CNT_WIDTH{1'b1}} : sum[BYTE_CNT_WIDTH-1:0];
  endfunction

  assign idle_s      = (state_q == IDLE);
  assign lk_accept_s = lookup_req & idle_s;
  assign wr_accept_s = wr_req & idle_s;
  assign rd_accept_s = cnt_rd_req & idle_s;

  // Flush sweep FSM: one entry per cycle, further flush pulses ignored while sweeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_idx_q <= '0;
          if (flush) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            flush_idx_q <= '0;
          end else begin
            flush_idx_q <= flush_idx_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          flush_idx_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      key_q[wr_addr]  <= wr_key;
      mask_q[wr_addr] <= wr_mask;
      data_q[wr_addr] <= wr_data;
    end
  end

  // Match against the table as it stands before this cycle's write lands.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] & ~|((lookup_key ^ key_q[i]) & ~mask_q[i]);
    end
  end

  always_comb begin
    hit_s      = |match_s;
    hit_addr_s = '0;
    hit_data_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_addr_s = match_s[i] ? ADDR_WIDTH'(i) : hit_addr_s;
      hit_data_s = match_s[i] ? data_q[i] : hit_data_s;
    end
  end

  // Clear (read or sweep) is applied first, so a same-cycle hit leaves exactly its own increment.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      clr_s[i] = (rd_accept_s & cnt_rd_clear & (cnt_rd_addr == ADDR_WIDTH'(i)))
               | ((state_q == FLUSH) & (flush_idx_q == ADDR_WIDTH'(i)));
      inc_s[i] = ack_hit_q & (ack_addr_q == ADDR_WIDTH'(i));
      pkts_base_s[i]  = clr_s[i] ? '0 : pkts_q[i];
      bytes_base_s[i] = clr_s[i] ? '0 : bytes_q[i];
      pkts_d[i]  = inc_s[i] ? sat_inc(pkts_base_s[i]) : pkts_base_s[i];
      bytes_d[i] = inc_s[i] ? sat_add(bytes_base_s[i], ack_size_q) : bytes_base_s[i];
      if ((state_q == FLUSH) && (flush_idx_q == ADDR_WIDTH'(i))) begin
        valid_d[i] = 1'b0;
      end else if (wr_accept_s && (wr_addr == ADDR_WIDTH'(i))) begin
        valid_d[i] = wr_valid;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pkts_q[i]  <= '0;
        bytes_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pkts_q  <= pkts_d;
      bytes_q <= bytes_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_size_q  <= '0;
      ack_q      <= 1'b0;
      ack_hit_q  <= 1'b0;
      ack_miss_q <= 1'b0;
      ack_addr_q <= '0;
      ack_data_q <= '0;
      ack_size_q <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_pkts_q  <= '0;
      rd_bytes_q <= '0;
    end else begin
      s1_vld_q   <= lk_accept_s;
      s1_hit_q   <= lk_accept_s & hit_s;
      s1_addr_q  <= lk_accept_s ? hit_addr_s : '0;
      s1_data_q  <= lk_accept_s ? hit_data_s : '0;
      s1_size_q  <= lookup_pkt_size;
      ack_q      <= s1_vld_q;
      ack_hit_q  <= s1_hit_q;
      ack_miss_q <= s1_vld_q & ~s1_hit_q;
      ack_addr_q <= s1_addr_q;
      ack_data_q <= s1_data_q;
      ack_size_q <= s1_size_q;
      wr_ack_q   <= wr_accept_s;
      rd_ack_q   <= rd_accept_s;
      rd_pkts_q  <= rd_accept_s ? pkts_q[cnt_rd_addr] : '0;
      rd_bytes_q <= rd_accept_s ? bytes_q[cnt_rd_addr] : '0;
    end
  end

  // Ready must drop the instant reset asserts, so it is gated by the reset pin itself.
  assign lookup_rdy  = reset & ~busy_q;
  assign busy        = busy_q;
  assign lookup_ack  = ack_q;
  assign lookup_hit  = ack_hit_q;
  assign lookup_miss = ack_miss_q;
  assign lookup_addr = ack_addr_q;
  assign lookup_data = ack_data_q;
  assign wr_ack      = wr_ack_q;
  assign cnt_rd_ack  = rd_ack_q;
  assign cnt_pkts    = rd_pkts_q;
  assign cnt_bytes   = rd_bytes_q;

endmodule

// File: tb/tb_ternary_match_table.sv
// Bench for ternary_match_table: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an array-based table model.
module tb_ternary_match_table;
  localparam int KW = 64, DW = 32, D = 32, AW = 5, SW = 12, PW = 8, BW = 16;
  localparam longint PMAX = (longint'(1) << PW) - 1;
  localparam longint BMAX = (longint'(1) << BW) - 1;
  localparam logic [KW-1:0] K_AB = 64'h0000_0000_0000_00AB;

  logic clk, reset;
  logic lookup_req, lookup_rdy, lookup_ack, lookup_hit, lookup_miss;
  logic [KW-1:0] lookup_key;
  logic [SW-1:0] lookup_pkt_size;
  logic [DW-1:0] lookup_data;
  logic [AW-1:0] lookup_addr;
  logic wr_req, wr_valid, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_key, wr_mask;
  logic [DW-1:0] wr_data;
  logic cnt_rd_req, cnt_rd_clear, cnt_rd_ack;
  logic [AW-1:0] cnt_rd_addr;
  logic [PW-1:0] cnt_pkts;
  logic [BW-1:0] cnt_bytes;
  logic flush, busy;

  int checks = 0;
  int failures = 0;

  // Narrow counters so both saturation limits are reachable in a short run.
  ternary_match_table #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(D), .PKT_SIZE_WIDTH(SW),
                        .PKT_CNT_WIDTH(PW), .BYTE_CNT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_key(lookup_key), .lookup_pkt_size(lookup_pkt_size),
    .lookup_rdy(lookup_rdy), .lookup_ack(lookup_ack), .lookup_hit(lookup_hit),
    .lookup_miss(lookup_miss), .lookup_data(lookup_data), .lookup_addr(lookup_addr),
    .wr_req(wr_req), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_key(wr_key),
    .wr_mask(wr_mask), .wr_data(wr_data), .wr_ack(wr_ack),
    .cnt_rd_req(cnt_rd_req), .cnt_rd_clear(cnt_rd_clear), .cnt_rd_addr(cnt_rd_addr),
    .cnt_rd_ack(cnt_rd_ack), .cnt_pkts(cnt_pkts), .cnt_bytes(cnt_bytes),
    .flush(flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit vld; bit hit; int addr; longint data; int size; } res_t;

  logic [KW-1:0] m_key [D];
  logic [KW-1:0] m_mask[D];
  logic [DW-1:0] m_data[D];
  bit            m_valid[D];
  longint        m_pkts[D], m_bytes[D];
  bit            m_fl;
  int            m_fk;
  res_t          p1, cur, nw;
  bit            e_wr_ack, e_rd_ack, m_idle;
  longint        e_rd_p, e_rd_b;

  function automatic res_t no_res();
    res_t r;
    r.vld = 0; r.hit = 0; r.addr = 0; r.data = 0; r.size = 0;
    return r;
  endfunction

  function automatic res_t find(input logic [KW-1:0] k, input int sz);
    res_t r;
    r = no_res();
    r.vld = 1; r.size = sz;
    for (int i = 0; i < D; i++)
      if (!r.hit && m_valid[i] && (((k ^ m_key[i]) & ~m_mask[i]) == '0)) begin
        r.hit = 1; r.addr = i; r.data = m_data[i];
      end
    return r;
  endfunction

  function automatic longint min2(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        m_valid[i] = 0; m_pkts[i] = 0; m_bytes[i] = 0;
      end
      m_fl = 0; m_fk = 0; p1 = no_res(); cur = no_res();
      e_wr_ack = 0; e_rd_ack = 0; e_rd_p = 0; e_rd_b = 0;
    end else begin
      m_idle = !m_fl;
      nw = no_res();
      if (lookup_req && m_idle) nw = find(lookup_key, int'(lookup_pkt_size));
      e_rd_ack = cnt_rd_req && m_idle;
      if (e_rd_ack) begin
        e_rd_p = m_pkts[cnt_rd_addr];
        e_rd_b = m_bytes[cnt_rd_addr];
        if (cnt_rd_clear) begin m_pkts[cnt_rd_addr] = 0; m_bytes[cnt_rd_addr] = 0; end
      end
      if (m_fl) begin m_valid[m_fk] = 0; m_pkts[m_fk] = 0; m_bytes[m_fk] = 0; end
      if (cur.vld && cur.hit) begin
        m_pkts[cur.addr]  = min2(m_pkts[cur.addr] + 1, PMAX);
        m_bytes[cur.addr] = min2(m_bytes[cur.addr] + cur.size, BMAX);
      end
      e_wr_ack = wr_req && m_idle;
      if (e_wr_ack) begin
        m_key[wr_addr] = wr_key; m_mask[wr_addr] = wr_mask;
        m_data[wr_addr] = wr_data; m_valid[wr_addr] = wr_valid;
      end
      if (m_fl) begin
        m_fk++;
        if (m_fk == D) m_fl = 0;
      end else if (flush) begin
        m_fl = 1; m_fk = 0;
      end
      cur = p1;
      p1 = nw;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("lookup_ack", lookup_ack, cur.vld);
    if (cur.vld) begin
      chk("lookup_hit", lookup_hit, cur.hit);
      chk("lookup_miss", lookup_miss, !cur.hit);
      chk("lookup_addr", lookup_addr, cur.addr);
      chk("lookup_data", lookup_data, cur.data);
    end
    chk("wr_ack", wr_ack, e_wr_ack);
    chk("busy", busy, m_fl);
    chk("lookup_rdy", lookup_rdy, reset && !m_fl);
    chk("cnt_rd_ack", cnt_rd_ack, e_rd_ack);
    if (e_rd_ack) begin
      chk("cnt_pkts", cnt_pkts, e_rd_p);
      chk("cnt_bytes", cnt_bytes, e_rd_b);
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic do_write(input int a, input logic [KW-1:0] k, input logic [KW-1:0] m,
                          input logic [DW-1:0] d, input bit v);
    bit got;
    got = 0;
    wr_req = 1'b1; wr_addr = AW'(a); wr_key = k; wr_mask = m; wr_data = d; wr_valid = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (wr_ack) begin got = 1; break; end
    end
    wr_req = 1'b0;
    chk("wr_ack_seen", got, 1);
  endtask

  task automatic do_lookup_chk(input string name, input logic [KW-1:0] k, input int sz,
                               input bit eh, input int ea, input longint ed);
    lookup_req = 1'b1; lookup_key = k; lookup_pkt_size = SW'(sz);
    @(negedge clk);
    lookup_req = 1'b0;
    @(negedge clk);
    chk({name, "_ack"}, lookup_ack, 1);
    chk({name, "_hit"}, lookup_hit, eh);
    chk({name, "_miss"}, lookup_miss, !eh);
    chk({name, "_addr"}, lookup_addr, ea);
    chk({name, "_data"}, lookup_data, ed);
  endtask

  task automatic rd_chk(input string name, input int a, input bit clr,
                        input longint ep, input longint eb);
    cnt_rd_req = 1'b1; cnt_rd_addr = AW'(a); cnt_rd_clear = clr;
    @(negedge clk);
    cnt_rd_req = 1'b0; cnt_rd_clear = 1'b0;
    chk({name, "_ack"}, cnt_rd_ack, 1);
    chk({name, "_pkts"}, cnt_pkts, ep);
    chk({name, "_bytes"}, cnt_bytes, eb);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [KW-1:0] rand_mask();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return 64'h0000_0000_0000_00FF;
      2: return 64'hFFFF_FFFF_0000_0000;
      default: return {$urandom, $urandom} & {$urandom, $urandom};
    endcase
  endfunction

  logic [KW-1:0] pool [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; lookup_req = 1'b0; lookup_key = '0; lookup_pkt_size = '0;
    wr_req = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_key = '0; wr_mask = '0; wr_data = '0;
    cnt_rd_req = 1'b0; cnt_rd_clear = 1'b0; cnt_rd_addr = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};
    idle_cycles(3);
    chk("rst_rdy", lookup_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", lookup_ack, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", lookup_rdy, 1);

    // Masked entry 3 and exact entry 7 share the low byte.
    do_write(3, K_AB, 64'hFFFF_FFFF_FFFF_FF00, 32'h55, 1'b1);
    do_write(7, K_AB, 64'h0, 32'h77, 1'b1);
    do_lookup_chk("masked_hit", 64'h1200_0000_0000_00AB, 20, 1, 3, 64'h55);
    do_lookup_chk("priority", K_AB, 30, 1, 3, 64'h55);
    do_write(3, K_AB, 64'hFFFF_FFFF_FFFF_FF00, 32'h55, 1'b0);
    do_lookup_chk("after_inval", K_AB, 10, 1, 7, 64'h77);
    do_lookup_chk("miss", 64'h0000_0000_0000_00AC, 5, 0, 0, 0);
    idle_cycles(1);
    rd_chk("e3_kept", 3, 1'b0, 2, 50);
    rd_chk("e7_clr", 7, 1'b1, 1, 10);

    // Four back-to-back hits on entry 7.
    lookup_req = 1'b1; lookup_key = K_AB; lookup_pkt_size = 12'd64;
    @(negedge clk); lookup_pkt_size = 12'd100;
    @(negedge clk); lookup_pkt_size = 12'd1500;
    @(negedge clk); lookup_pkt_size = 12'd4095;
    @(negedge clk); lookup_req = 1'b0;
    idle_cycles(3);
    rd_chk("burst4", 7, 1'b1, 4, 5759);
    rd_chk("burst4_zero", 7, 1'b0, 0, 0);

    // Walk the packet counter up to all-ones minus one, then into saturation.
    lookup_req = 1'b1; lookup_pkt_size = '0;
    for (int i = 0; i < 254; i++) @(negedge clk);
    lookup_req = 1'b0;
    idle_cycles(3);
    rd_chk("preload", 7, 1'b0, 254, 0);
    lookup_req = 1'b1; lookup_pkt_size = 12'd4095;
    idle_cycles(2);
    lookup_req = 1'b0;
    idle_cycles(3);
    rd_chk("pkt_sat", 7, 1'b0, 255, 8190);
    lookup_req = 1'b1;
    idle_cycles(20);
    lookup_req = 1'b0;
    idle_cycles(3);
    rd_chk("byte_sat", 7, 1'b0, 255, 65535);
    lookup_req = 1'b1; lookup_pkt_size = 12'd77;
    @(negedge clk); lookup_req = 1'b0;
    @(negedge clk);
    chk("clr_hit_ack", lookup_ack, 1);
    rd_chk("clr_same_cycle", 7, 1'b1, 255, 65535);
    rd_chk("clr_hit_result", 7, 1'b0, 1, 77);

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (wr_req) begin
        if (wr_ack) wr_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(0, D - 1));
        wr_valid = ($urandom_range(0, 4) != 0);
        wr_key = pool[$urandom_range(0, 3)]; wr_mask = rand_mask(); wr_data = $urandom;
      end
      lookup_req = ($urandom_range(0, 1) == 1);
      lookup_key = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) lookup_key = lookup_key ^ KW'($urandom_range(0, 255));
      lookup_pkt_size = SW'($urandom_range(0, 4095));
      cnt_rd_req = ($urandom_range(0, 5) == 0);
      cnt_rd_addr = AW'($urandom_range(0, D - 1));
      cnt_rd_clear = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    lookup_req = 1'b0; cnt_rd_req = 1'b0; cnt_rd_clear = 1'b0; flush = 1'b0;
    for (int t = 0; t < 100 && wr_req; t++) begin
      @(negedge clk);
      if (wr_ack) wr_req = 1'b0;
    end
    chk("rand_drain", wr_req, 0);
    while (busy) @(negedge clk);
    idle_cycles(3);

    // Flush sweep with a write held off and a second flush pulse ignored.
    begin
      int bc, fall, ackc;
      bc = 0; fall = -1; ackc = -1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (busy) begin
          bc++;
          chk("flush_rdy_low", lookup_rdy, 0);
        end else if (fall < 0) begin
          fall = c;
        end
        if (wr_ack) begin ackc = c; wr_req = 1'b0; end
        if (c == 10) begin
          wr_req = 1'b1; wr_addr = AW'(5); wr_valid = 1'b0; wr_key = K_AB; wr_mask = '0;
        end
        flush = (c == 20);
        @(negedge clk);
      end
      chk("flush_busy_cycles", bc, 32);
      chk("flush_wr_ack_cycle", ackc, fall + 1);
    end
    do_lookup_chk("flush_miss_ab", K_AB, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_lookup_chk("flush_miss_pool", pool[i], 1, 0, 0, 0);

    // Reset during a flush with a lookup in flight.
    do_write(7, K_AB, 64'h0, 32'h77, 1'b1);
    lookup_req = 1'b1; lookup_key = K_AB; lookup_pkt_size = 12'd9; flush = 1'b1;
    @(negedge clk);
    lookup_req = 1'b0; flush = 1'b0;
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_rdy", lookup_rdy, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ack", lookup_ack, 0);
    chk("arst_hit", lookup_hit, 0);
    chk("arst_miss", lookup_miss, 0);
    chk("arst_data", lookup_data, 0);
    chk("arst_addr", lookup_addr, 0);
    chk("arst_wr_ack", wr_ack, 0);
    chk("arst_rd_ack", cnt_rd_ack, 0);
    chk("arst_pkts", cnt_pkts, 0);
    chk("arst_bytes", cnt_bytes, 0);
    idle_cycles(3);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_ack", lookup_ack, 0);
    end
    do_lookup_chk("post_reset_miss", K_AB, 9, 0, 0, 0);
    rd_chk("post_reset_cnt", 7, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
